fetch_controller: RTL

//  Sequences the word-indexed, combinational-read instruction memory: owns the fetch PC,

---
 rtl/fetch_controller.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fetch_controller.sv
// Fetch PC sequencer feeding a 2-entry skid FIFO toward decode.
// Optional bounds check enabled by defining FETCH_BOUNDS_CHECK_EN.
module fetch_controller #(
  parameter int ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int PC_INC    = 1,
  parameter int MEM_WORDS = 6000
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt_req,
  output logic              halted,
  output logic              fault
);

  typedef enum logic [1:0] {
    RUN,
    HALT,
    FAULT
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [1:0]        cnt;
  logic [31:0]       d0, d1;
  logic [ADDR_W-1:0] p0, p1;
  logic              oob;
  logic              pop;
  logic              push;

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(MEM_WORDS);
  assign oob   = (fetch_pc >= LIMIT);
  assign fault = (state == FAULT);
`else
  assign oob   = 1'b0;
  assign fault = 1'b0;
`endif

  assign imem_addr  = fetch_pc;
  assign inst_valid = (cnt != 2'd0);
  assign inst_data  = d0;
  assign inst_pc    = p0;
  assign halted     = (state == HALT);

  assign pop  = inst_valid & inst_ready;
  assign push = (state == RUN) & ~redirect_valid & ~halt_req
              & ~oob & (~cnt[1] | pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      fetch_pc <= RESET_PC;
      cnt      <= 2'd0;
      d0       <= '0;
      d1       <= '0;
      p0       <= '0;
      p1       <= '0;
    end else if (redirect_valid) begin
      // Flush wins; any same-cycle pop is simply lost with the rest.
      cnt      <= 2'd0;
      fetch_pc <= redirect_pc;
      if (halt_req || state == HALT)
        state <= HALT;
      else
        state <= RUN;
    end else begin
      unique case (state)
        RUN: begin
          if (halt_req)
            state <= HALT;
          else if (oob)
            state <= FAULT;
        end
        HALT: begin
          if (!halt_req)
            state <= RUN;
        end
        FAULT: state <= FAULT;
        default: state <= RUN;
      endcase

      if (push)
        fetch_pc <= fetch_pc + ADDR_W'(PC_INC);

      if (pop && push) begin
        if (cnt == 2'd2) begin
          d0 <= d1;
          p0 <= p1;
          d1 <= imem_rdata;
          p1 <= fetch_pc;
        end else begin
          d0 <= imem_rdata;
          p0 <= fetch_pc;
        end
      end else if (pop) begin
        d0  <= d1;
        p0  <= p1;
        cnt <= cnt - 2'd1;
      end else if (push) begin
        if (cnt == 2'd0) begin
          d0 <= imem_rdata;
          p0 <= fetch_pc;
        end else begin
          d1 <= imem_rdata;
          p1 <= fetch_pc;
        end
        cnt <= cnt + 2'd1;
      end
    end
  end

endmodule
